// File: rtl/npu_pkg.sv
// -----------------------------------------------------------------------------
// npu_pkg
// Shared NPU definitions: matrix geometry, element/matrix types used by the
// leaky_relu stage and the matrix serializer, and the serializer FSM states.
// -----------------------------------------------------------------------------
package npu_pkg;

    localparam int DIM    = 10;
    localparam int DATA_W = 16;

    typedef logic signed [DATA_W-1:0] elem_t;
    typedef elem_t [DIM-1:0][DIM-1:0] matrix_t;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } ser_state_t;

endpackage

// File: rtl/matrix_index_counter.sv
// -----------------------------------------------------------------------------
// matrix_index_counter
// Row/column index generator for walking a DIM x DIM matrix.
//
// Configuration macro: MATRIX_SER_COLMAJOR_EN
//   undefined : row-major walk (col moves fastest, row steps on col wrap)
//   defined   : column-major walk (row moves fastest, col steps on row wrap)
//
// Ports
//   clk     : clock, rising edge
//   rst     : asynchronous active-low reset, index forced to (0,0)
//   clear   : synchronous return to (0,0), wins over advance
//   advance : step to the next index in traversal order
//   row     : current row index
//   col     : current column index
//   last    : index is (DIM-1, DIM-1), the final element in either order
// -----------------------------------------------------------------------------
module matrix_index_counter #(
    parameter  int DIM   = npu_pkg::DIM,
    localparam int IDX_W = (DIM > 1) ? $clog2(DIM) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             advance,
    output logic [IDX_W-1:0] row,
    output logic [IDX_W-1:0] col,
    output logic             last
);

    localparam logic [IDX_W-1:0] MAX_IDX = IDX_W'(DIM - 1);

    logic [IDX_W-1:0] r_row;
    logic [IDX_W-1:0] r_col;

    // Index walk. Advancing from the final element wraps back to (0,0), so a
    // completed matrix leaves the counter ready for the next one.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_row <= '0;
            r_col <= '0;
        end else if (clear) begin
            r_row <= '0;
            r_col <= '0;
        end else if (advance) begin
`ifdef MATRIX_SER_COLMAJOR_EN
            if (r_row == MAX_IDX) begin
                r_row <= '0;
                r_col <= (r_col == MAX_IDX) ? '0 : r_col + 1'b1;
            end else begin
                r_row <= r_row + 1'b1;
            end
`else
            if (r_col == MAX_IDX) begin
                r_col <= '0;
                r_row <= (r_row == MAX_IDX) ? '0 : r_row + 1'b1;
            end else begin
                r_col <= r_col + 1'b1;
            end
`endif
        end
    end

    assign row  = r_row;
    assign col  = r_col;
    assign last = (r_row == MAX_IDX) && (r_col == MAX_IDX);

endmodule

// File: rtl/matrix_serializer.sv
// -----------------------------------------------------------------------------
// matrix_serializer
// Captures a complete DIM x DIM activation matrix in one cycle and streams its
// elements out one per handshake with their row/column indices.
//
// Configuration macro: MATRIX_SER_COLMAJOR_EN (column-major traversal when
// defined, row-major otherwise; handled inside matrix_index_counter).
//
// Ports
//   clk       : clock, rising edge
//   rst       : asynchronous active-low reset
//   in_matrix : whole matrix from leaky_relu, element [row][col]
//   in_valid  : in_matrix holds a complete matrix
//   in_ready  : block is idle and will capture on in_valid
//   out_data  : current element, bit-exact copy of the captured value
//   out_valid : out_data is valid
//   out_ready : downstream accepts out_data
//   out_last  : out_data is the final element (DIM-1, DIM-1)
//   out_row   : row index of out_data
//   out_col   : column index of out_data
// -----------------------------------------------------------------------------
module matrix_serializer
    import npu_pkg::*;
#(
    parameter  int DIM    = npu_pkg::DIM,
    parameter  int DATA_W = npu_pkg::DATA_W,
    localparam int IDX_W  = (DIM > 1) ? $clog2(DIM) : 1
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic signed [DIM-1:0][DIM-1:0][DATA_W-1:0] in_matrix,
    input  logic                                    in_valid,
    output logic                                    in_ready,
    output logic signed [DATA_W-1:0]                out_data,
    output logic                                    out_valid,
    input  logic                                    out_ready,
    output logic                                    out_last,
    output logic [IDX_W-1:0]                        out_row,
    output logic [IDX_W-1:0]                        out_col
);

    ser_state_t                             r_state;
    logic                                   r_in_ready;
    logic                                   r_out_valid;
    logic [DIM-1:0][DIM-1:0][DATA_W-1:0]    r_bank;

    logic                                   w_capture;
    logic                                   w_advance;
    logic [IDX_W-1:0]                       w_row;
    logic [IDX_W-1:0]                       w_col;
    logic                                   w_last;

    // in_ready is registered, so a capture is only possible once it has
    // risen after reset; this keeps the first post-reset edge capture-free.
    assign w_capture = (r_state == IDLE) && r_in_ready && in_valid;
    assign w_advance = r_out_valid && out_ready;

    matrix_index_counter #(
        .DIM (DIM)
    ) u_index (
        .clk     (clk),
        .rst     (rst),
        .clear   (w_capture),
        .advance (w_advance),
        .row     (w_row),
        .col     (w_col),
        .last    (w_last)
    );

    // Two-state control. Leaving STREAM on the final handshake goes to IDLE
    // only; the next capture needs a fresh edge with in_ready already high.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_bank      <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                    if (w_capture) begin
                        r_bank      <= in_matrix;
                        r_state     <= STREAM;
                        r_in_ready  <= 1'b0;
                        r_out_valid <= 1'b1;
                    end
                end
                STREAM: begin
                    if (out_ready && w_last) begin
                        r_state     <= IDLE;
                        r_in_ready  <= 1'b1;
                        r_out_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_in_ready  <= 1'b0;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    // The bank and index only change on capture/handshake, so the element
    // and its indices stay stable while out_ready is low.
    assign out_data  = r_bank[w_row][w_col];
    assign out_row   = w_row;
    assign out_col   = w_col;
    assign out_last  = r_out_valid && w_last;
    assign out_valid = r_out_valid;
    assign in_ready  = r_in_ready;

endmodule

// File: tb/tb_matrix_serializer.sv
// -----------------------------------------------------------------------------
// tb_matrix_serializer
// Directed self-checking bench for matrix_serializer: reset state, ramp
// stream, backpressure, busy input, mid-stream reset and extreme values.
// Expected traversal follows MATRIX_SER_COLMAJOR_EN when it is defined.
// -----------------------------------------------------------------------------
module tb_matrix_serializer;
    import npu_pkg::*;

    localparam int NUM   = DIM * DIM;
    localparam int IDX_W = (DIM > 1) ? $clog2(DIM) : 1;

    logic              clk;
    logic              rst;
    matrix_t           in_matrix;
    logic              in_valid;
    logic              in_ready;
    logic signed [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;
    logic [IDX_W-1:0]  out_row;
    logic [IDX_W-1:0]  out_col;

    int checks;
    int errors;

    matrix_t rampMat;
    matrix_t sevenMat;
    matrix_t extremeMat;

    matrix_serializer dut (
        .clk       (clk),
        .rst       (rst),
        .in_matrix (in_matrix),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .out_row   (out_row),
        .out_col   (out_col)
    );

    // Free-running clock, period 10
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One comparison: counts it, and on mismatch counts the error and reports
    task automatic checkOutput(input string tag, input logic [DATA_W-1:0] obs,
                               input logic [DATA_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0d (0x%h), expected %0d (0x%h)",
                   tag, $signed(obs), obs, $signed(exp), exp);
        end
    endtask

    // Present a matrix with in_valid for exactly one rising edge
    task automatic applyStimulus(input matrix_t m);
        in_matrix = m;
        in_valid  = 1'b1;
        @(negedge clk);
        in_valid  = 1'b0;
    endtask

    // Walk the stream beat by beat from the beat-0 negedge. stallAt holds
    // out_ready low for 3 cycles at that beat, injectBusy drives a new matrix
    // from beat 20 to the end, abortAt pulls reset low at that beat.
    task automatic runStream(input matrix_t expMat, input int stallAt,
                             input bit injectBusy, input int abortAt);
        int k;
        int r;
        int c;
        int stallCnt;
        bit aborted;
        k        = 0;
        stallCnt = 0;
        aborted  = 1'b0;
        while (k < NUM && !aborted) begin
`ifdef MATRIX_SER_COLMAJOR_EN
            r = k % DIM;
            c = k / DIM;
`else
            r = k / DIM;
            c = k % DIM;
`endif
            if (k == abortAt) begin
                rst = 1'b0;
                #1;
                checkOutput("abort out_valid", out_valid, 1'b0);
                checkOutput("abort in_ready", in_ready, 1'b0);
                checkOutput("abort out_data", out_data, '0);
                checkOutput("abort out_last", out_last, 1'b0);
                checkOutput("abort out_row", out_row, '0);
                checkOutput("abort out_col", out_col, '0);
                aborted = 1'b1;
            end else begin
                checkOutput($sformatf("beat%0d out_valid", k), out_valid, 1'b1);
                checkOutput($sformatf("beat%0d in_ready", k), in_ready, 1'b0);
                checkOutput($sformatf("beat%0d out_data", k), out_data, expMat[r][c]);
                checkOutput($sformatf("beat%0d out_row", k), out_row, DATA_W'(r));
                checkOutput($sformatf("beat%0d out_col", k), out_col, DATA_W'(c));
                checkOutput($sformatf("beat%0d out_last", k), out_last, (k == NUM - 1));
                if (k == stallAt && stallCnt < 3) begin
                    out_ready = 1'b0;
                    stallCnt++;
                end else begin
                    out_ready = 1'b1;
                    k++;
                end
                if (injectBusy && k >= 20) begin
                    in_matrix = sevenMat;
                    in_valid  = 1'b1;
                end
                @(negedge clk);
            end
        end
        if (!aborted) begin
            checkOutput("done in_ready", in_ready, 1'b1);
            checkOutput("done out_valid", out_valid, 1'b0);
            checkOutput("done out_last", out_last, 1'b0);
            in_valid = 1'b0;
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_matrix = '0;

        for (int i = 0; i < DIM; i++) begin
            for (int j = 0; j < DIM; j++) begin
                rampMat[i][j]    = elem_t'(i * 10 + j - 50);
                sevenMat[i][j]   = elem_t'(7);
                extremeMat[i][j] = ((i + j) % 2 == 0) ? elem_t'(-32768) : elem_t'(32767);
            end
        end

        $display("[TB] reset state");
        in_matrix = rampMat;
        in_valid  = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("reset in_ready", in_ready, 1'b0);
        checkOutput("reset out_valid", out_valid, 1'b0);
        checkOutput("reset out_last", out_last, 1'b0);
        checkOutput("reset out_data", out_data, '0);
        checkOutput("reset out_row", out_row, '0);
        checkOutput("reset out_col", out_col, '0);
        in_valid = 1'b0;
        rst      = 1'b1;
        #1;
        checkOutput("release in_ready before edge", in_ready, 1'b0);
        @(negedge clk);
        checkOutput("release in_ready", in_ready, 1'b1);
        checkOutput("release out_valid", out_valid, 1'b0);
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("idle out_valid", out_valid, 1'b0);

        $display("[TB] ramp stream");
        applyStimulus(rampMat);
        checkOutput("ramp first data", out_data, 16'hFFCE);
        runStream(rampMat, -1, 1'b0, -1);

        $display("[TB] backpressure at beat 37");
        applyStimulus(rampMat);
        runStream(rampMat, 36, 1'b0, -1);

        $display("[TB] busy input during stream");
        applyStimulus(rampMat);
        runStream(rampMat, -1, 1'b1, -1);
        @(negedge clk);
        checkOutput("busy no recapture", out_valid, 1'b0);

        $display("[TB] reset at beat 50");
        applyStimulus(rampMat);
        runStream(rampMat, -1, 1'b0, 49);
        @(negedge clk);
        checkOutput("abort held out_valid", out_valid, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("abort release in_ready", in_ready, 1'b1);
        checkOutput("abort release out_valid", out_valid, 1'b0);
        applyStimulus(rampMat);
        runStream(rampMat, -1, 1'b0, -1);

        $display("[TB] extreme values");
        applyStimulus(extremeMat);
        checkOutput("extreme first data", out_data, 16'h8000);
        runStream(extremeMat, 5, 1'b0, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/matrix_serializer.md
MATRIX_SERIALIZER -- requirements
Module: matrix_serializer

Interface
REQ-001 SHALL have parameter DIM, default 10, the matrix side length (DIM x DIM elements).
REQ-002 SHALL have parameter DATA_W, default 16, the signed element width.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-low reset (asserted at 0).
REQ-005 SHALL have port in_matrix, input, signed [DATA_W-1:0] [DIM-1:0][DIM-1:0]: activation matrix from the leaky_relu output.
REQ-006 SHALL have port in_valid, input, 1 bit: in_matrix holds a complete matrix.
REQ-007 SHALL have port in_ready, output, 1 bit: the block can capture a matrix.
REQ-008 SHALL have port out_data, output, signed [DATA_W-1:0]: current streamed element.
REQ-009 SHALL have port out_valid, output, 1 bit: out_data is valid.
REQ-010 SHALL have port out_ready, input, 1 bit: the downstream consumer accepts out_data.
REQ-011 SHALL have port out_last, output, 1 bit: out_data is the final element of the matrix.
REQ-012 SHALL have ports out_row and out_col, output, $clog2(DIM) bits each: indices of out_data.

Function
REQ-013 SHALL implement an FSM with two states, IDLE and STREAM.
REQ-014 In IDLE, in_ready SHALL be 1 and out_valid SHALL be 0.
REQ-015 In IDLE with in_valid=1, the block SHALL capture all DIM*DIM elements into an internal bank on that edge and enter STREAM with index (0,0).
REQ-016 The first element SHALL be valid on the cycle after capture (latency 1).
REQ-017 In STREAM, in_ready SHALL be 0, out_valid SHALL be 1, and in_valid and in_matrix SHALL be ignored.
REQ-018 The default order SHALL be row-major: col increments and wraps to 0 at DIM-1, and row increments on that wrap.
REQ-019 The index SHALL advance only on out_valid&&out_ready.
REQ-020 With out_ready=0, out_data, out_row, out_col and out_last SHALL hold stable.
REQ-021 out_last SHALL be 1 exactly when the index is (DIM-1,DIM-1).
REQ-022 A handshake on the last element SHALL return the FSM to IDLE, with in_ready=1 on the next cycle and no back-to-back capture on that same edge.
REQ-023 out_data SHALL pass element values bit-exact, with no sign or width change.

Reset
REQ-024 While rst=0, the block SHALL be in IDLE with in_ready=0, out_valid=0, out_last=0, out_data=0, out_row=0, out_col=0, and the bank cleared.
REQ-025 in_ready SHALL rise on the first clock edge after rst deasserts.
REQ-026 Reset asserted mid-STREAM SHALL abort the transfer immediately (asynchronously), with no partial resumption afterwards.

Configuration
REQ-027 With macro MATRIX_SER_COLMAJOR_EN defined, traversal SHALL be column-major: row increments first, and col increments on the row wrap.
REQ-028 Without MATRIX_SER_COLMAJOR_EN, traversal SHALL be row-major; out_last SHALL be (DIM-1,DIM-1) in both modes.

Structure
REQ-029 Package npu_pkg SHALL hold DIM, DATA_W, typedef elem_t (signed [DATA_W-1:0]) and typedef matrix_t (elem_t [DIM-1:0][DIM-1:0]), shared with leaky_relu.
REQ-030 The row/col wrap logic SHALL be a sub-module matrix_index_counter (inputs: clear, advance; outputs: row, col, last), which also contains the MATRIX_SER_COLMAJOR_EN ordering.

Verification
REQ-031 Ramp test: in_matrix[i][j]=i*10+j-50 with out_ready held at 1 -> 100 beats of -50..49 in order, out_last on beat 100 only, and in_ready=1 on the following cycle.
REQ-032 Backpressure test: drop out_ready for 3 cycles at beat 37 -> out_data=-14 and out_row/out_col=3/6 held stable, with no beat lost or duplicated.
REQ-033 Busy test: assert in_valid with a new matrix (all 7) during STREAM -> it is ignored, and the ramp stream completes unchanged.
REQ-034 Reset test: drive rst=0 at beat 50 -> out_valid=0 at once; after release, in_ready=1 and a new capture restarts at (0,0).
REQ-035 Column-major test: with MATRIX_SER_COLMAJOR_EN defined and the ramp matrix -> beats -50,-40,...,40,-49,...; the last beat is 49 with out_last=1.
REQ-036 Extremes test: a matrix of -32768 and 32767 alternating -> output is bit-exact, with no sign corruption.
